// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
package alu_pkg;

  localparam int unsigned OpW  = 4;
  localparam int unsigned OppW = 16;
  localparam int unsigned CntW = 6;

  // Op indices double as the bit position of the ALU one-hot select.
  typedef enum logic [OpW-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpNeg = 4'd2,
    OpMul = 4'd3,
    OpDiv = 4'd4,
    OpAnd = 4'd5,
    OpOr  = 4'd6,
    OpRor = 4'd7,
    OpRol = 4'd8,
    OpSll = 4'd9,
    OpSra = 4'd10,
    OpSrl = 4'd11,
    OpNot = 4'd12,
    OpInc = 4'd13
  } op_e;

  localparam logic [OpW-1:0] FirstIllegalOp = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns LAT(op)-1, the value loaded into the down-counter on accept.
  function automatic logic [CntW-1:0] op_cnt_init(input logic [OpW-1:0] op,
                                                  input int unsigned simple_lat,
                                                  input int unsigned mul_lat,
                                                  input int unsigned div_lat);
    int unsigned lat;
    if (op == OpMul) begin
      lat = mul_lat;
    end else if (op == OpDiv) begin
      lat = div_lat;
    end else begin
      lat = simple_lat;
    end
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that tracks the remaining EXEC cycles of an ALU op.
module alu_lat_counter
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: accepts one op, drives the ALU one-hot select for the op's
// latency, captures the 64-bit result and pulses done.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SIMPLE_LAT = 1,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_LAT    = 34
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OpW-1:0]  req_op,
  input  logic [31:0]     req_x,
  input  logic [31:0]     req_y,
  input  logic            abort,
  output logic [31:0]     alu_x,
  output logic [31:0]     alu_y,
  output logic [OppW-1:0] alu_opp,
  input  logic [63:0]     alu_z,
  output logic [31:0]     z_hi,
  output logic [31:0]     z_lo,
  output logic            done,
  output logic            div0_err,
  output logic            ill_err
);

  state_e          state_q, state_d;
  logic [31:0]     x_q, x_d, y_q, y_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [OppW-1:0] opp_q, opp_d;
  logic            div0_q, div0_d, ill_q, ill_d;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt_init;
  logic            req_ill, req_div0;

  assign req_ill  = (req_op >= FirstIllegalOp);
  assign req_div0 = (req_op == OpDiv) && (req_y == '0);
  assign cnt_init = op_cnt_init(req_op, SIMPLE_LAT, MUL_LAT, DIV_LAT);

  alu_lat_counter u_lat_counter (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_init),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opp_d    = opp_q;
    div0_d   = div0_q;
    ill_d    = ill_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d    = req_x;
          y_d    = req_y;
          div0_d = req_div0;
          ill_d  = req_ill;
          if (req_ill || req_div0) begin
            // Error ops never reach the ALU; the select stays zero.
            hi_d    = '0;
            lo_d    = '0;
            state_d = DONE;
          end else begin
            opp_d    = OppW'(1) << req_op;
            cnt_load = 1'b1;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        // Abort takes priority over a completing op in the same cycle.
        if (abort) begin
          opp_d   = '0;
          state_d = IDLE;
        end else if (cnt_zero) begin
          hi_d    = alu_z[63:32];
          lo_d    = alu_z[31:0];
          opp_d   = '0;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opp_q   <= '0;
      div0_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opp_q   <= opp_d;
      div0_q  <= div0_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_opp   = opp_q;
  assign z_hi      = hi_q;
  assign z_lo      = lo_q;
  assign div0_err  = div0_q;
  assign ill_err   = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer; the bench also plays the role of the ALU.
module tb_alu_op_sequencer;

  localparam int unsigned LAT_S = 1;
  localparam int unsigned LAT_M = 2;
  localparam int unsigned LAT_D = 34;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        abort = 1'b0;
  logic [31:0] alu_x, alu_y;
  logic [15:0] alu_opp;
  logic [63:0] alu_z;
  logic [31:0] z_hi, z_lo;
  logic        done, div0_err, ill_err;

  alu_op_sequencer #(
    .SIMPLE_LAT (LAT_S),
    .MUL_LAT    (LAT_M),
    .DIV_LAT    (LAT_D)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .abort     (abort),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_opp   (alu_opp),
    .alu_z     (alu_z),
    .z_hi      (z_hi),
    .z_lo      (z_lo),
    .done      (done),
    .div0_err  (div0_err),
    .ill_err   (ill_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    logic        ill;
    bit          aborted;
    int unsigned t_done;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int unsigned last_t = 0;

  function automatic int unsigned lat_of(input int unsigned op);
    if (op == 3) return LAT_M;
    if (op == 4) return LAT_D;
    return LAT_S;
  endfunction

  // Reference ALU: ops 0..13 in index order.
  function automatic logic [63:0] ref_alu(input int unsigned op, input logic [31:0] x,
                                          input logic [31:0] y);
    int unsigned s;
    s = int'(y[4:0]);
    case (op)
      0:  return {32'd0, x + y};
      1:  return {32'd0, x - y};
      2:  return {32'd0, 32'd0 - x};
      3:  return 64'(x) * 64'(y);
      4:  return {x % y, x / y};
      5:  return {32'd0, x & y};
      6:  return {32'd0, x | y};
      7:  return {32'd0, (x >> s) | (x << (32 - s))};
      8:  return {32'd0, (x << s) | (x >> (32 - s))};
      9:  return {32'd0, x << s};
      10: return {32'd0, 32'($signed(x) >>> s)};
      11: return {32'd0, x >> s};
      12: return {32'd0, ~x};
      13: return {32'd0, x + 32'd1};
      default: return '0;
    endcase
  endfunction

  function automatic int unsigned opp_idx(input logic [15:0] o);
    int unsigned r = 0;
    for (int i = 0; i < 16; i++) if (o[i]) r = i;
    return r;
  endfunction

  // ALU stand-in: result only becomes valid once the select has been stable for LAT cycles.
  int unsigned hold = 0;
  logic [15:0] prev_opp = '0;
  always @(negedge clk) begin
    if (alu_opp != '0) hold <= (alu_opp == prev_opp) ? hold + 1 : 1;
    else hold <= 0;
    prev_opp <= alu_opp;
  end

  always_comb begin
    alu_z = 64'hDEAD_BEEF_0BAD_F00D;
    if ($onehot(alu_opp) && (hold == lat_of(opp_idx(alu_opp))))
      alu_z = ref_alu(opp_idx(alu_opp), alu_x, alu_y);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit abt);
    exp_t        e;
    logic [63:0] z;
    int unsigned w = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    while (!req_ready) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        bad++;
        $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
      end
    end
    last_t    = cyc + 1;
    e.op      = int'(op);
    e.aborted = abt;
    e.ill     = (op >= 4'd14);
    e.div0    = (op == 4'd4) && (y == 32'd0);
    if (e.ill || e.div0) begin
      e.hi     = '0;
      e.lo     = '0;
      e.t_done = last_t;
    end else begin
      z        = ref_alu(int'(op), x, y);
      e.hi     = z[63:32];
      e.lo     = z[31:0];
      e.t_done = last_t + lat_of(int'(op));
    end
    sb.push_back(e);
    if (!abt) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_x     = $urandom;
    req_y     = $urandom;
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  logic [15:0] mon_last_opp = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_last_opp = '0;
      end else begin
        if ((alu_opp != '0) && (mon_last_opp == '0)) begin
          if (sb.size() == 0) begin
            check("opp_unexpected", 64'(alu_opp), 64'd0);
          end else begin
            check("opp_select", 64'(alu_opp),
                  (sb[0].ill || sb[0].div0) ? 64'd0 : (64'd1 << sb[0].op));
          end
        end
        mon_last_opp = alu_opp;
        if (done) begin
          if (sb.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
          end else begin
            e = sb.pop_front();
            check("done_after_abort", 64'(e.aborted), 64'd0);
            check("z_hi", 64'(z_hi), 64'(e.hi));
            check("z_lo", 64'(z_lo), 64'(e.lo));
            check("div0_err", 64'(div0_err), 64'(e.div0));
            check("ill_err", 64'(ill_err), 64'(e.ill));
            check("done_cycle", 64'(cyc), 64'(e.t_done));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_opp"}, 64'(alu_opp), 64'd0);
    check({tag, "_x"}, 64'(alu_x), 64'd0);
    check({tag, "_y"}, 64'(alu_y), 64'd0);
    check({tag, "_zhi"}, 64'(z_hi), 64'd0);
    check({tag, "_zlo"}, 64'(z_lo), 64'd0);
    check({tag, "_flags"}, {61'd0, done, div0_err, ill_err}, 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] y;
    #1;
    check_reset_values("reset");
    check("reset_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    issue(4'd0, 32'd10, 32'd5, 1'b0);
    issue(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(4'd4, 32'd20, 32'd5, 1'b0);
    issue(4'd4, 32'd20, 32'd0, 1'b0);
    issue(4'd15, 32'd7, 32'd9, 1'b0);
    issue(4'd9, 32'd1, 32'd2, 1'b0);
    issue(4'd14, 32'd1, 32'd1, 1'b0);
    issue(4'd10, 32'h8000_0000, 32'd4, 1'b0);

    // Abort a DIV in its 10th EXEC cycle.
    issue(4'd4, 32'd1000, 32'd7, 1'b1);
    while (cyc < last_t + 9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_opp", 64'(alu_opp), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    sb.delete(0);
    repeat (40) @(negedge clk);
    check("abort_zhi", 64'(z_hi), 64'(last_hi));
    check("abort_zlo", 64'(z_lo), 64'(last_lo));

    // Abort while idle must not disturb the next op.
    abort = 1'b1;
    issue(4'd13, 32'hFFFF_FFFF, 32'd0, 1'b0);
    abort = 1'b0;

    // Asynchronous reset in the middle of a MUL.
    issue(4'd3, 32'd123, 32'd456, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check_reset_values("midreset");
    sb.delete(0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op = 4'($urandom_range(0, 15));
      y  = $urandom;
      if ((op == 4'd4) && ($urandom_range(0, 3) == 0)) y = 32'd0;
      issue(op, $urandom, y, 1'b0);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
